mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/type_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// State and ownership encodings for the fetch/data memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;
endpackage

// File: rtl/type_pkg.sv
// Shared bus types for the core <-> memory path.
package type_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [BE_W-1:0]   byte_en_t;
endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters,
// one transaction in flight, with a bus watchdog that terminates stuck accesses.
module mem_arbiter
  import type_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_valid,
  input  addr_t    i_addr,
  output logic     i_ready,
  output data_t    i_rdata,
  input  logic     d_valid,
  input  addr_t    d_addr,
  input  data_t    d_wdata,
  input  byte_en_t d_byte_enable,
  output logic     d_ready,
  output data_t    d_rdata,
  output logic     mem_valid,
  output addr_t    mem_addr,
  output data_t    mem_wdata,
  output byte_en_t mem_byte_enable,
  output logic     mem_we,
  input  logic     mem_ready,
  input  data_t    mem_rdata,
  output logic     bus_timeout
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t     state_q, state_d;
  arb_owner_t     owner_q, owner_d;
  arb_owner_t     last_grant_q, last_grant_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic           mem_valid_q, mem_valid_d;
  addr_t          mem_addr_q, mem_addr_d;
  data_t          mem_wdata_q, mem_wdata_d;
  byte_en_t       mem_be_q, mem_be_d;
  logic           mem_we_q, mem_we_d;
  logic           i_ready_q, i_ready_d;
  logic           d_ready_q, d_ready_d;
  data_t          i_rdata_q, i_rdata_d;
  data_t          d_rdata_q, d_rdata_d;
  logic           bus_timeout_q, bus_timeout_d;
  logic           grant_d;
  logic           wdog_fire;
  data_t          rsp_data;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    timeout_cnt_d = timeout_cnt_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    mem_we_d      = mem_we_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ready_d     = 1'b0;
    d_ready_d     = 1'b0;
    bus_timeout_d = 1'b0;
    grant_d       = 1'b0;
    wdog_fire     = 1'b0;
    rsp_data      = '0;

    case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          // On a tie the data side wins unless it was the last one served.
          grant_d       = d_valid && (!i_valid || (last_grant_q == OWN_I));
          owner_d       = grant_d ? OWN_D : OWN_I;
          last_grant_d  = owner_d;
          state_d       = BUSY;
          timeout_cnt_d = '0;
          mem_valid_d   = 1'b1;
          if (grant_d) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_byte_enable;
            mem_we_d    = |d_byte_enable;
          end else begin
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            mem_we_d    = 1'b0;
          end
        end
      end
      BUSY: begin
        wdog_fire = WDOG_EN && (timeout_cnt_q == CNT_LIM);
        // A completion on the limit cycle wins over the watchdog.
        if (mem_ready || wdog_fire) begin
          state_d       = RESP;
          mem_valid_d   = 1'b0;
          bus_timeout_d = !mem_ready;
          rsp_data      = mem_ready ? mem_rdata : '0;
          if (owner_q == OWN_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = rsp_data;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = rsp_data;
          end
        end else begin
          timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_I;
      last_grant_q  <= OWN_I;
      timeout_cnt_q <= '0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      mem_we_q      <= 1'b0;
      i_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      timeout_cnt_q <= timeout_cnt_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      mem_we_q      <= mem_we_d;
      i_ready_q     <= i_ready_d;
      d_ready_q     <= d_ready_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  assign mem_valid       = mem_valid_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_we          = mem_we_q;
  assign i_ready         = i_ready_q;
  assign d_ready         = d_ready_q;
  assign i_rdata         = i_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign bus_timeout     = bus_timeout_q;
endmodule
